// File: rtl/tlul_sram_slave.sv
// TL-UL slave endpoint backed by a word-addressed SRAM with a fixed wait-state count.
// One transaction in flight; errors are decided at accept time and reported on the D channel.
module tlul_sram_slave #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned SRC_WIDTH    = 1,
    parameter int unsigned SINK_WIDTH   = 1,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PARAM_WIDTH  = 3,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h0000_1000,
    parameter int unsigned WAIT_CYCLES  = 2
) (
    input  logic                    clk_24,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int unsigned LANE_W = $clog2(MASK_WIDTH);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] END_ADDR =
        {1'b0, BASE_ADDR} + (ADDR_WIDTH + 1)'(MEM_DEPTH * MASK_WIDTH);
    localparam logic [SIZE_WIDTH-1:0] MAX_SIZE = SIZE_WIDTH'(LANE_W);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    cap_get;
    logic                    cap_err;
    logic [SIZE_WIDTH-1:0]   cap_size;
    logic [SRC_WIDTH-1:0]    cap_source;
    logic [IDX_W-1:0]        cap_idx;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic [IDX_W-1:0]        a_idx;
    logic                    a_write;
    logic                    a_get;
    logic                    a_err;
    logic                    accept;

    logic                    r_get;
    logic                    r_err;
    logic [SIZE_WIDTH-1:0]   r_size;
    logic [SRC_WIDTH-1:0]    r_source;
    logic [IDX_W-1:0]        r_idx;
    logic                    load_resp;
    logic                    unused_param;

    assign unused_param = ^a_param;

    assign a_ready    = (state == IDLE) && !reset;
    assign accept     = a_ready && a_valid;
    assign d_param    = '0;
    assign d_sink     = '0;

    assign offset     = a_address - BASE_ADDR;
    assign a_idx      = IDX_W'(offset >> LANE_W);
    assign align_mask = ~({ADDR_WIDTH{1'b1}} << a_size);
    assign a_write    = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    assign a_get      = (a_opcode == OP_GET);
    assign a_err      = !(a_write || a_get)
                     || (a_size > MAX_SIZE)
                     || (|(a_address & align_mask))
                     || (a_address < BASE_ADDR)
                     || ({1'b0, a_address} >= END_ADDR);

    // With zero wait states the response is built straight from the A channel on the accept edge.
    always_comb begin
        r_get    = cap_get;
        r_err    = cap_err;
        r_size   = cap_size;
        r_source = cap_source;
        r_idx    = cap_idx;
        if (state == IDLE) begin
            r_get    = a_get;
            r_err    = a_err;
            r_size   = a_size;
            r_source = a_source;
            r_idx    = a_idx;
        end
    end

    assign load_resp = ((state == IDLE) && a_valid && (WAIT_CYCLES == 0))
                    || ((state == WAIT) && (cnt == '0));

    always_ff @(posedge clk_24) begin
        if (accept && a_write && !a_err) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (a_mask[i]) mem[a_idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_get    <= 1'b0;
            cap_err    <= 1'b0;
            cap_size   <= '0;
            cap_source <= '0;
            cap_idx    <= '0;
            d_valid    <= 1'b0;
            d_opcode   <= '0;
            d_size     <= '0;
            d_source   <= '0;
            d_data     <= '0;
            d_error    <= 1'b0;
        end else begin
            if (load_resp) begin
                d_valid  <= 1'b1;
                d_opcode <= r_get ? OP_ACK_DATA : OP_ACK;
                d_size   <= r_size;
                d_source <= r_source;
                d_error  <= r_err;
                d_data   <= (r_get && !r_err) ? mem[r_idx] : '0;
            end
            case (state)
                IDLE: begin
                    if (a_valid) begin
                        cap_get    <= a_get;
                        cap_err    <= a_err;
                        cap_size   <= a_size;
                        cap_source <= a_source;
                        cap_idx    <= a_idx;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                RESP: begin
                    if (d_ready) begin
                        state    <= IDLE;
                        d_valid  <= 1'b0;
                        d_opcode <= '0;
                        d_size   <= '0;
                        d_source <= '0;
                        d_data   <= '0;
                        d_error  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlul_sram_slave.sv
// Scoreboard bench for tlul_sram_slave: requests push model-predicted responses,
// an independent D-channel monitor pops and compares them.
module tb_tlul_sram_slave;

    localparam int W = 2;

    logic        clk_24 = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;

    tlul_sram_slave #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEM_DEPTH   (256),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (W)
    ) dut (
        .clk_24    (clk_24),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_data    (d_data),
        .d_error   (d_error)
    );

    always #5 clk_24 = ~clk_24;

    int cyc = 0;
    always @(posedge clk_24) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic        src;
        logic        err;
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hold_low = 0;
    bit          in_resp = 0;
    bit          post_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference rules: legal opcodes, size up to one word, natural alignment, 1 KiB window at 0x1000.
    function automatic bit model_err(input logic [2:0] op, input logic [2:0] size, input logic [31:0] addr);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if ((addr % (32'd1 << size)) != 0) return 1'b1;
        if (addr < 32'h1000 || addr >= 32'h1000 + 256 * 4) return 1'b1;
        return 1'b0;
    endfunction

    // Must be called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] size, input logic src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        exp_t e;
        int   t = 0;
        int   idx;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_param = 3'($urandom);
        while (!a_ready) begin
            @(negedge clk_24);
            if (++t > 200) begin
                timeout("accept");
                a_valid = 1'b0;
                return;
            end
        end
        e.err  = model_err(op, size, addr);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size;
        e.src  = src;
        e.acc  = cyc + 1;
        e.data = 32'h0;
        if (!e.err) begin
            idx = int'((addr - 32'h1000) / 4);
            if (op == 3'd4) e.data = model[idx];
            else for (int b = 0; b < 4; b++) if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        q.push_back(e);
        @(negedge clk_24);
        a_valid = 1'b0;
    endtask

    // Wiggle the A channel with junk while busy; none of it may be taken.
    task automatic settle();
        int t = 0;
        while (!a_ready) begin
            a_valid = 1'($urandom); a_opcode = 3'($urandom); a_address = $urandom;
            a_data = $urandom; a_mask = 4'($urandom); a_size = 3'($urandom);
            @(negedge clk_24);
            if (++t > 200) begin
                timeout("settle");
                break;
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic reset_mid(input int k, input logic [31:0] addr);
        issue(3'd0, 3'd2, 1'b1, addr, 4'hF, $urandom);
        repeat (k) @(negedge clk_24);
        #2 reset = 1'b1;
        #1;
        chk("rst_d_valid", d_valid, 0);
        chk("rst_a_ready", a_ready, 0);
        void'(q.pop_back());
        @(negedge clk_24);
        #2 reset = 1'b0;
        hold_low = 0;
        repeat (3) begin
            @(negedge clk_24);
            chk("post_rst_d_valid", d_valid, 0);
            chk("post_rst_a_ready", a_ready, 1);
        end
        issue(3'd4, 3'd2, 1'b0, addr, 4'hF, 32'h0);
        settle();
    endtask

    initial begin
        d_ready = 1'b0;
        forever begin
            @(negedge clk_24);
            if (reset) begin
                in_resp = 0;
                post_chk = 0;
                d_ready = 1'b0;
                continue;
            end
            if (hold_low > 0) begin
                d_ready = 1'b0;
                if (d_valid) hold_low--;
            end else begin
                d_ready = ($urandom % 4) != 0;
            end
            if (d_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got d_valid=1 required no response (cycle %0d)", cyc);
                end else begin
                    if (!in_resp) chk("latency", 64'(cyc - q[0].acc), 64'(W));
                    in_resp = 1;
                    chk("d_fields", {d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data},
                        {q[0].op, 3'b000, q[0].size, q[0].src, 1'b0, q[0].err, q[0].data});
                    chk("a_ready_busy", a_ready, 0);
                    if (d_ready) begin
                        void'(q.pop_front());
                        in_resp = 0;
                        post_chk = 1;
                    end
                end
            end else if (post_chk) begin
                chk("a_ready_after", a_ready, 1);
                post_chk = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op, size;
        logic [31:0] addr;
        int          r, t;

        reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = 1'b0; a_address = '0; a_mask = '0; a_data = '0;
        #1;
        chk("reset_a_ready", a_ready, 0);
        chk("reset_d_outputs", {d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_error, d_data}, 0);
        repeat (3) @(negedge clk_24);
        #2 reset = 1'b0;
        @(negedge clk_24);
        chk("idle_a_ready", a_ready, 1);
        chk("idle_d_valid", d_valid, 0);

        for (int i = 0; i < 256; i++) begin
            issue(3'd0, 3'd2, 1'(i), 32'h1000 + 32'(i * 4), 4'hF, $urandom);
            settle();
        end

        issue(3'd0, 3'd2, 1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF); settle();
        issue(3'd4, 3'd2, 1'b0, 32'h1000, 4'hF, 32'h0);         settle();
        issue(3'd0, 3'd2, 1'b0, 32'h1004, 4'hF, 32'hFFFF_FFFF); settle();
        issue(3'd1, 3'd2, 1'b1, 32'h1004, 4'h5, 32'h1122_3344); settle();
        issue(3'd4, 3'd2, 1'b1, 32'h1004, 4'hF, 32'h0);         settle();
        issue(3'd4, 3'd2, 1'b0, 32'h0FFC, 4'hF, 32'h0);         settle();
        issue(3'd4, 3'd2, 1'b0, 32'h1400, 4'hF, 32'h0);         settle();
        issue(3'd4, 3'd2, 1'b0, 32'h13FC, 4'hF, 32'h0);         settle();
        issue(3'd0, 3'd2, 1'b0, 32'h1002, 4'hF, 32'h0BAD_0BAD); settle();
        issue(3'd4, 3'd2, 1'b0, 32'h1000, 4'hF, 32'h0);         settle();
        issue(3'd2, 3'd2, 1'b1, 32'h1000, 4'hF, 32'h0);         settle();
        issue(3'd4, 3'd3, 1'b1, 32'h1000, 4'hF, 32'h0);         settle();

        hold_low = 10;
        issue(3'd4, 3'd2, 1'b1, 32'h1004, 4'hF, 32'h0);
        settle();

        reset_mid(0, 32'h1010);
        hold_low = 20;
        reset_mid(W, 32'h1020);

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom % 10);
            op = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom);
            size = (($urandom % 8) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            case ($urandom % 8)
                0: begin
                    r = int'($urandom % 4);
                    addr = (r == 0) ? 32'h0FFC : (r == 1) ? 32'h13FC : (r == 2) ? 32'h1400 : 32'h1000;
                end
                1: addr = $urandom;
                default: begin
                    addr = 32'h1000 + $urandom_range(0, 1023);
                    if (size <= 3'd2) addr = addr & ~((32'd1 << size) - 1);
                end
            endcase
            issue(op, size, 1'($urandom), addr, 4'($urandom), $urandom);
            settle();
        end

        t = 0;
        while (q.size() > 0 && t < 2000) begin
            @(negedge clk_24);
            t++;
        end
        if (q.size() > 0) timeout("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
